// File: rtl/sd_wb_backing_ram.sv
// sd_wb_backing_ram: Wishbone B3 slave on-chip RAM that SD block transfers land in.
// Define SD_WB_BACKING_RAM_WAIT_EN to insert WAIT_CYCLES wait states before the first ack.
module sd_wb_backing_ram #(
   parameter int DEPTH_LOG2  = 12,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk_50,
   input  logic        reset_n,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic [31:0] wbs_dat_o,
   input  logic [3:0]  wbs_sel_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   output logic        wbs_ack_o,
   input  logic [2:0]  wbs_cti_i,
   input  logic [1:0]  wbs_bte_i,
   output logic [31:0] stat_words
);
   localparam int AW = DEPTH_LOG2;
   typedef enum logic [1:0] {
      IDLE,
      ACK
`ifdef SD_WB_BACKING_RAM_WAIT_EN
      , WAIT
`endif
   } state_t;
   if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("WAIT_CYCLES must be within 0..15");
   end
   logic [31:0]   mem [2**AW];
   state_t        state;
   logic          ack_r, req, burst, unused;
   logic [AW-1:0] word, mask, nxt, rd_addr, addr_r;
   logic [31:0]   q_r, byp_dat;
   logic [3:0]    byp_sel;
`ifdef SD_WB_BACKING_RAM_WAIT_EN
   logic [3:0]    cnt;
`endif
   assign req       = wbs_cyc_i & wbs_stb_i;
   assign wbs_ack_o = ack_r & req;
   assign burst     = wbs_cti_i == 3'b010;
   assign word      = wbs_adr_i[AW+1:2];
   assign mask      = wbs_bte_i == 2'b01 ? AW'(3) : wbs_bte_i == 2'b10 ? AW'(7) :
                      wbs_bte_i == 2'b11 ? AW'(15) : '1;
   assign nxt       = (word & ~mask) | ((word + 1'b1) & mask);
   // Stalled or waiting cycles keep re-reading the held address so resumed beats see fresh data
   assign rd_addr   = state == IDLE ? word : (wbs_ack_o && burst) ? nxt : addr_r;
   assign unused    = ^{wbs_adr_i[31:AW+2], wbs_adr_i[1:0]};
   always_ff @(posedge clk_50)
      if (wbs_ack_o && wbs_we_i)
         for (int i = 0; i < 4; i++)
            if (wbs_sel_i[i]) mem[word][8*i +: 8] <= wbs_dat_i[8*i +: 8];
   // Bypass lanes written on the same edge that reads them (write-first behaviour)
   always_comb begin
      wbs_dat_o = q_r;
      for (int i = 0; i < 4; i++)
         if (byp_sel[i]) wbs_dat_o[8*i +: 8] = byp_dat[8*i +: 8];
   end
   always_ff @(posedge clk_50 or negedge reset_n)
      if (!reset_n) begin
         state      <= IDLE;
         ack_r      <= 1'b0;
         addr_r     <= '0;
         q_r        <= '0;
         byp_sel    <= '0;
         byp_dat    <= '0;
         stat_words <= '0;
`ifdef SD_WB_BACKING_RAM_WAIT_EN
         cnt        <= '0;
`endif
      end else begin
         addr_r  <= rd_addr;
         q_r     <= mem[rd_addr];
         byp_sel <= (wbs_ack_o && wbs_we_i && word == rd_addr) ? wbs_sel_i : 4'b0;
         byp_dat <= wbs_dat_i;
         if (wbs_ack_o) stat_words <= stat_words + 32'd1;
         case (state)
            IDLE:
               if (req) begin
`ifdef SD_WB_BACKING_RAM_WAIT_EN
                  state <= WAIT_CYCLES > 0 ? WAIT : ACK;
                  ack_r <= WAIT_CYCLES == 0;
                  cnt   <= 4'(WAIT_CYCLES - 1);
`else
                  state <= ACK;
                  ack_r <= 1'b1;
`endif
               end
`ifdef SD_WB_BACKING_RAM_WAIT_EN
            WAIT:
               if (!req) state <= IDLE;
               else if (cnt == 4'd0) begin
                  state <= ACK;
                  ack_r <= 1'b1;
               end else cnt <= cnt - 4'd1;
`endif
            ACK:
               if (!wbs_cyc_i || (wbs_stb_i && !burst)) begin
                  state <= IDLE;
                  ack_r <= 1'b0;
               end
            default: begin
               state <= IDLE;
               ack_r <= 1'b0;
            end
         endcase
      end
endmodule

// File: doc/sd_wb_backing_ram.md
Name: sd_wb_backing_ram

Overview:
- Wishbone B3 slave that consumes the SD device core's wishbone master port.
- Provides the block-storage backing memory that SD block reads and writes land in, as an on-chip synchronous RAM.
- Supports classic single cycles and registered-feedback incrementing bursts (linear and wrap-4/8/16).
- Runs in the clk_50 domain: the core's wbm_clk_o is clk_50.

Parameters:
- DEPTH_LOG2, 12: RAM depth is 2^DEPTH_LOG2 32-bit words (default 16 KiB, 32 SD blocks).
- WAIT_CYCLES, 2: extra wait states before the first ack of each cycle or burst. Used only when the optional feature is compiled in; legal range 0..15.

Ports:
- clk_50  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous active-low reset, released synchronously by upstream logic.
- wbs_adr_i  in  32  byte address; word index = adr[DEPTH_LOG2+1:2]; upper bits ignored (aliasing).
- wbs_dat_i  in  32  write data.
- wbs_dat_o  out  32  read data, valid when wbs_ack_o=1 and we=0.
- wbs_sel_i  in  4  byte-lane enables for writes; sel[0]=bits 7:0.
- wbs_cyc_i  in  1  bus cycle.
- wbs_stb_i  in  1  strobe.
- wbs_we_i  in  1  1=write.
- wbs_ack_o  out  1  acknowledge.
- wbs_cti_i  in  3  000 classic, 010 incrementing burst, 111 end-of-burst; all other codes are treated as 000.
- wbs_bte_i  in  2  00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
- stat_words  out  32  count of acknowledged word transfers, wraps at 2^32.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; ack_r=0; wbs_dat_o=0; stat_words=0. RAM contents are not reset.
- Ack gating: wbs_ack_o = ack_r & wbs_cyc_i & wbs_stb_i (combinational gate on the registered ack). An ack is never presented without an active strobe.
- Transfer: a transfer completes on every edge where wbs_ack_o=1.
  - Write: RAM[word] byte lanes with sel=1 take wbs_dat_i; word is taken from wbs_adr_i of that cycle.
  - stat_words increments by 1.
- RAM: single-port synchronous read; 1-cycle read latency.
- State machine:
  - IDLE: on cyc&stb, present the word address to the RAM. Go to WAIT if WAIT_CYCLES>0 (feature on), else ACK; set ack_r accordingly.
  - WAIT: count down WAIT_CYCLES, holding the RAM address. On the last count set ack_r, go to ACK. If cyc or stb drops, go to IDLE.
  - ACK: ack_r=1; wbs_dat_o=RAM q.
    - Classic (cti 000) or end-of-burst (cti 111): on the transfer edge, clear ack_r and go to IDLE. Minimum one idle cycle between classic cycles: a classic read takes 2 cycles per word.
    - Incrementing burst (cti 010): on the transfer edge, present next_addr(wbs_adr_i) to the RAM and keep ack_r=1 (0-wait back-to-back), one word per cycle.
    - If stb drops with cyc held: keep state and address. Resume acking when stb returns, with the data re-read from the held address.
    - If cyc drops: IDLE, ack_r=0.
- next_addr: word+1 for linear. For wrap N, low log2(N) bits increment modulo N and upper bits are held. Word index wraps modulo 2^DEPTH_LOG2.
- Read-after-write inside a burst: the next word read returns the just-written data if the addresses match (RAM write-first, or bypass mux).
- cti changing mid-burst from 010 to 111: the final word is acked, then IDLE. A burst with the first beat at cti=111 behaves as classic.
- Reset mid-burst: immediate return to IDLE with ack deasserted. A partially applied burst is not rolled back.

Optional Feature:
- Macro: SD_WB_BACKING_RAM_WAIT_EN.
- Defined: WAIT state compiled in. Exactly WAIT_CYCLES idle cycles between stb sampled and the first ack of each classic cycle or burst. No waits between beats of one burst.
- Undefined: WAIT state, counter and WAIT_CYCLES usage are removed. First ack is always one cycle after stb is sampled.

Test Plan:
- Classic write 0xDEADBEEF to adr 0x10 with sel=1111, then classic read of 0x10 -> each ack is a 1-cycle pulse, 1 cycle after stb; read returns 0xDEADBEEF; stat_words=2.
- Byte write of 0x000000AA to adr 0x10 with sel=0001, over 0xDEADBEEF -> read returns 0xDEADBEAA.
- Linear read burst, 8 beats (cti 010 then 111 on the last), from adr 0x100 preloaded with word index values -> ack high 8 consecutive cycles; data 0x40..0x47; IDLE after.
- Wrap4 read burst from adr 0x108 (word 0x42), 4 beats -> words 0x42,0x43,0x40,0x41.
- Read burst with stb deasserted 3 cycles after beat 2 -> wbs_ack_o=0 during the gap; beat 3 data correct on resume; stat_words increments by exactly the beat count.
- Feature on, WAIT_CYCLES=2, classic read -> ack 3 cycles after stb. Assert reset_n=0 mid-burst -> ack_o=0 and stat_words=0 asynchronously; next classic cycle completes normally.
